// File: rtl/calc_entry_sequencer.sv
// -----------------------------------------------------------------------------
// calc_entry_sequencer
//   Keypad-to-ALU controller for the calculator. Builds two decimal operands
//   from key strobes (acc*10+digit, bounded by digit count and by 2**WIDTH-1),
//   latches the operator, issues one ALU request per EQUALS and drives the
//   display value / error indicator.
//
// Optional feature macro: CALC_CHAIN_EN
//   defined   : an operator key in SHOW chains the result into operand A and
//               moves straight to entering operand B.
//   undefined : an operator key in SHOW is ignored.
//
// Ports
//   clk, rst_n            clock, synchronous active-low reset
//   key_valid, key_code   1-cycle key strobe; 0-9 digit, 10 ADD, 11 SUB,
//                         12 MUL, 13 DIV, 14 EQUALS, 15 CLEAR
//   alu_req               request to the ALU (held while in EXEC)
//   alu_op, alu_a, alu_b  operator / operands, stable while alu_req
//   alu_ack               ALU response strobe (alu_result, alu_err valid)
//   disp_value, disp_err  display value and error indicator
//   busy                  high while waiting for the ALU
//   state_dbg             encoded state: 0 ENT_A, 1 ENT_B, 2 EXEC, 3 SHOW, 4 ERR
//
// ALU handshake: alu_req rises on entry to EXEC and stays high, with alu_op,
// alu_a and alu_b unchanged, until the cycle after alu_ack is sampled high
// (or the request is aborted by CLEAR, reset or timeout). alu_ack may already
// be high in the first cycle alu_req is high; alu_ack outside EXEC is ignored.
// -----------------------------------------------------------------------------
module calc_entry_sequencer #(
  parameter int WIDTH      = 8,
  parameter int MAX_DIGITS = 3,
  parameter int TIMEOUT    = 15
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             key_valid,
  input  logic [3:0]       key_code,
  output logic             alu_req,
  output logic [1:0]       alu_op,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  input  logic             alu_ack,
  input  logic [WIDTH-1:0] alu_result,
  input  logic             alu_err,
  output logic [WIDTH-1:0] disp_value,
  output logic             disp_err,
  output logic             busy,
  output logic [2:0]       state_dbg
);

  localparam int CW = $clog2(MAX_DIGITS + 1);
  localparam int TW = ($clog2(TIMEOUT + 1) < 4) ? 4 : $clog2(TIMEOUT + 1);
  // Extended width so acc*10+9 can be range-checked without overflow.
  localparam int XW = WIDTH + 4;

  localparam logic [CW-1:0] MAXD = CW'(MAX_DIGITS);
  localparam logic [TW-1:0] TMO  = TW'(TIMEOUT);
  localparam logic [XW-1:0] MAXV = (XW'(1) << WIDTH) - XW'(1);

  typedef enum logic [2:0] {
    ENT_A = 3'd0,
    ENT_B = 3'd1,
    EXEC  = 3'd2,
    SHOW  = 3'd3,
    ERR   = 3'd4
  } state_t;

  state_t           state, state_n;
  logic [WIDTH-1:0] a, a_n, b, b_n, result, result_n, disp_n;
  logic [1:0]       op, op_n;
  logic [CW-1:0]    a_cnt, a_cnt_n, b_cnt, b_cnt_n;
  logic [TW-1:0]    tmo_cnt, tmo_cnt_n, tmo_inc;
  logic [XW-1:0]    a_ext, b_ext;
  logic [3:0]       op_sub;
  logic             is_digit, is_op, is_eq, is_clr, a_ok, b_ok;

  function automatic logic [XW-1:0] acc10(input logic [WIDTH-1:0] acc,
                                          input logic [3:0] d);
    logic [XW-1:0] e;
    e = XW'(acc);
    return (e << 3) + (e << 1) + XW'(d);
  endfunction

  assign is_digit = key_valid && (key_code <= 4'd9);
  assign is_op    = key_valid && (key_code >= 4'd10) && (key_code <= 4'd13);
  assign is_eq    = key_valid && (key_code == 4'd14);
  assign is_clr   = key_valid && (key_code == 4'd15);
  assign op_sub   = key_code - 4'd10;
  assign a_ext    = acc10(a, key_code);
  assign b_ext    = acc10(b, key_code);
  // A digit is taken only if there is room for it and the value still fits.
  assign a_ok     = (a_cnt < MAXD) && (a_ext <= MAXV);
  assign b_ok     = (b_cnt < MAXD) && (b_ext <= MAXV);
  assign tmo_inc  = tmo_cnt + TW'(1);

  always_comb begin
    state_n   = state;
    a_n       = a;
    b_n       = b;
    op_n      = op;
    result_n  = result;
    a_cnt_n   = a_cnt;
    b_cnt_n   = b_cnt;
    tmo_cnt_n = tmo_cnt;
    if (is_clr) begin
      // CLEAR has priority over everything, including a coincident alu_ack.
      state_n   = ENT_A;
      a_n       = '0;
      b_n       = '0;
      op_n      = '0;
      result_n  = '0;
      a_cnt_n   = '0;
      b_cnt_n   = '0;
      tmo_cnt_n = '0;
    end else begin
      case (state)
        ENT_A: begin
          if (is_digit && a_ok) begin
            a_n     = a_ext[WIDTH-1:0];
            a_cnt_n = a_cnt + CW'(1);
          end else if (is_op && (a_cnt != '0)) begin
            op_n    = op_sub[1:0];
            b_n     = '0;
            b_cnt_n = '0;
            state_n = ENT_B;
          end
        end
        ENT_B: begin
          if (is_digit && b_ok) begin
            b_n     = b_ext[WIDTH-1:0];
            b_cnt_n = b_cnt + CW'(1);
          end else if (is_op && (b_cnt == '0)) begin
            op_n = op_sub[1:0];
          end else if (is_eq && (b_cnt != '0)) begin
            tmo_cnt_n = '0;
            state_n   = EXEC;
          end
        end
        EXEC: begin
          if (alu_ack) begin
            if (alu_err) begin
              state_n = ERR;
            end else begin
              result_n = alu_result;
              state_n  = SHOW;
            end
          end else begin
            tmo_cnt_n = tmo_inc;
            if (tmo_inc >= TMO) state_n = ERR;
          end
        end
        SHOW: begin
          if (is_digit) begin
            a_n     = WIDTH'(key_code);
            a_cnt_n = CW'(1);
            state_n = ENT_A;
          end
`ifdef CALC_CHAIN_EN
          else if (is_op) begin
            a_n     = result;
            a_cnt_n = CW'(1);
            op_n    = op_sub[1:0];
            b_n     = '0;
            b_cnt_n = '0;
            state_n = ENT_B;
          end
`endif
        end
        ERR: begin
          state_n = ERR;
        end
        default: begin
          state_n = ENT_A;
        end
      endcase
    end

    case (state_n)
      ENT_A:      disp_n = a_n;
      ENT_B, EXEC: disp_n = b_n;
      SHOW:       disp_n = result_n;
      default:    disp_n = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= ENT_A;
      a          <= '0;
      b          <= '0;
      op         <= '0;
      result     <= '0;
      a_cnt      <= '0;
      b_cnt      <= '0;
      tmo_cnt    <= '0;
      alu_req    <= 1'b0;
      busy       <= 1'b0;
      disp_value <= '0;
      disp_err   <= 1'b0;
    end else begin
      state      <= state_n;
      a          <= a_n;
      b          <= b_n;
      op         <= op_n;
      result     <= result_n;
      a_cnt      <= a_cnt_n;
      b_cnt      <= b_cnt_n;
      tmo_cnt    <= tmo_cnt_n;
      alu_req    <= (state_n == EXEC);
      busy       <= (state_n == EXEC);
      disp_value <= disp_n;
      disp_err   <= (state_n == ERR);
    end
  end

  assign alu_op    = op;
  assign alu_a     = a;
  assign alu_b     = b;
  assign state_dbg = state;

endmodule

// File: tb/tb_calc_entry_sequencer.sv
// -----------------------------------------------------------------------------
// tb_calc_entry_sequencer
//   Directed scenarios for the calculator key sequencer followed by a long
//   randomized run checked cycle by cycle against a behavioural model that
//   tracks operands as plain integers.
// -----------------------------------------------------------------------------
module tb_calc_entry_sequencer;

  localparam int W    = 8;
  localparam int MAXD = 3;
  localparam int TMO  = 15;
  localparam int MAXV = 255;

  // ---------------- clock / reset ----------------
  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         key_valid = 1'b0;
  logic [3:0]   key_code = 4'd0;
  logic         alu_ack = 1'b0;
  logic         alu_err = 1'b0;
  logic [W-1:0] alu_result = '0;
  logic         alu_req, busy, disp_err;
  logic [1:0]   alu_op;
  logic [W-1:0] alu_a, alu_b, disp_value;
  logic [2:0]   state_dbg;

  always #5 clk = ~clk;

  calc_entry_sequencer #(.WIDTH(W), .MAX_DIGITS(MAXD), .TIMEOUT(TMO)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .key_valid  (key_valid),
    .key_code   (key_code),
    .alu_req    (alu_req),
    .alu_op     (alu_op),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_ack    (alu_ack),
    .alu_result (alu_result),
    .alu_err    (alu_err),
    .disp_value (disp_value),
    .disp_err   (disp_err),
    .busy       (busy),
    .state_dbg  (state_dbg)
  );

  int total = 0;
  int bad   = 0;

  // ---------------- reference model ----------------
  // Phase uses the externally visible codes: 0 entering A, 1 entering B,
  // 2 waiting for ALU, 3 showing result, 4 error.
  int m_st, m_a, m_b, m_op, m_res, m_ac, m_bc, m_wait;
  logic [31:0] exp_q[$];

  task automatic model_reset();
    m_st = 0; m_a = 0; m_b = 0; m_op = 0; m_res = 0; m_ac = 0; m_bc = 0; m_wait = 0;
  endtask

  // Applies the current input values as they will be seen at the next edge.
  task automatic model_step();
    int d;
    d = int'(key_code);
    if (!rst_n || (key_valid && d == 15)) begin
      model_reset();
    end else begin
      case (m_st)
        0: if (key_valid) begin
          if (d <= 9) begin
            if (m_ac < MAXD && m_a * 10 + d <= MAXV) begin
              m_a = m_a * 10 + d; m_ac = m_ac + 1;
            end
          end else if (d <= 13 && m_ac >= 1) begin
            m_op = d - 10; m_b = 0; m_bc = 0; m_st = 1;
          end
        end
        1: if (key_valid) begin
          if (d <= 9) begin
            if (m_bc < MAXD && m_b * 10 + d <= MAXV) begin
              m_b = m_b * 10 + d; m_bc = m_bc + 1;
            end
          end else if (d <= 13) begin
            if (m_bc == 0) m_op = d - 10;
          end else if (d == 14 && m_bc >= 1) begin
            m_st = 2; m_wait = 0;
          end
        end
        2: begin
          if (alu_ack) begin
            if (alu_err) m_st = 4;
            else begin m_res = int'(alu_result); m_st = 3; end
          end else begin
            m_wait = m_wait + 1;
            if (m_wait >= TMO) m_st = 4;
          end
        end
        3: if (key_valid) begin
          if (d <= 9) begin
            m_a = d; m_ac = 1; m_st = 0;
          end
`ifdef CALC_CHAIN_EN
          else if (d <= 13) begin
            m_a = m_res; m_ac = 1; m_op = d - 10; m_b = 0; m_bc = 0; m_st = 1;
          end
`endif
        end
        default: ;
      endcase
    end
  endtask

  function automatic logic [31:0] model_vec();
    int disp;
    case (m_st)
      0:       disp = m_a;
      1, 2:    disp = m_b;
      3:       disp = m_res;
      default: disp = 0;
    endcase
    return {m_st == 2, m_st == 2, m_st == 4, 3'(m_st), 8'(disp), 8'(m_a), 8'(m_b), 2'(m_op)};
  endfunction

  // ---------------- driver tasks ----------------
  task automatic drive_cycle(input logic kv, input logic [3:0] kc, input logic ack,
                             input logic aerr, input logic [W-1:0] ares, input logic rst);
    key_valid = kv; key_code = kc; alu_ack = ack; alu_err = aerr; alu_result = ares;
    rst_n = !rst;
    model_step();
    exp_q.push_back(model_vec());
    @(posedge clk); #1;
    key_valid = 1'b0; alu_ack = 1'b0; alu_err = 1'b0; rst_n = 1'b1;
  endtask

  task automatic press(input logic [3:0] k);
    drive_cycle(1'b1, k, 1'b0, 1'b0, '0, 1'b0);
  endtask

  task automatic idle();
    drive_cycle(1'b0, 4'd0, 1'b0, 1'b0, '0, 1'b0);
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    model_reset();
    drive_cycle(1'b0, 4'd0, 1'b0, 1'b0, '0, 1'b1);
    drive_cycle(1'b1, 4'd5, 1'b1, 1'b0, 8'd9, 1'b1);
    total++;
    if ({alu_req, busy, disp_err, state_dbg, disp_value, alu_a, alu_b, alu_op} !== 32'd0) begin
      bad++;
      $display("FAIL reset: req=%b busy=%b err=%b st=%0d disp=%0d a=%0d b=%0d op=%0d, want all 0",
               alu_req, busy, disp_err, state_dbg, disp_value, alu_a, alu_b, alu_op);
    end
  endtask

  task automatic test_basic();
    int req_cycles;
    req_cycles = 0;
    press(4'd15); press(4'd1); press(4'd2);
    total++;
    if ({state_dbg, disp_value} !== {3'd0, 8'd12}) begin
      bad++; $display("FAIL entry_a: st=%0d disp=%0d want st=0 disp=12", state_dbg, disp_value);
    end
    press(4'd10);
    total++;
    if ({state_dbg, disp_value, alu_op} !== {3'd1, 8'd0, 2'd0}) begin
      bad++; $display("FAIL op_latch: st=%0d disp=%0d op=%0d want 1/0/0", state_dbg, disp_value, alu_op);
    end
    press(4'd3); press(4'd4); press(4'd14);
    total++;
    if ({alu_req, busy, alu_op, alu_a, alu_b, disp_value, state_dbg} !==
        {1'b1, 1'b1, 2'd0, 8'd12, 8'd34, 8'd34, 3'd2}) begin
      bad++;
      $display("FAIL exec_issue: req=%b busy=%b op=%0d a=%0d b=%0d disp=%0d st=%0d want 1/1/0/12/34/34/2",
               alu_req, busy, alu_op, alu_a, alu_b, disp_value, state_dbg);
    end
    for (int i = 0; i < 3; i++) begin
      if (alu_req && alu_a == 8'd12 && alu_b == 8'd34 && alu_op == 2'd0) req_cycles++;
      if (i < 2) idle();
      else drive_cycle(1'b0, 4'd0, 1'b1, 1'b0, 8'd46, 1'b0);
    end
    total++;
    if (req_cycles !== 3) begin
      bad++; $display("FAIL req_hold: stable req cycles=%0d want 3", req_cycles);
    end
    total++;
    if ({alu_req, busy, disp_err, state_dbg, disp_value} !== {1'b0, 1'b0, 1'b0, 3'd3, 8'd46}) begin
      bad++;
      $display("FAIL show_result: req=%b busy=%b err=%b st=%0d disp=%0d want 0/0/0/3/46",
               alu_req, busy, disp_err, state_dbg, disp_value);
    end
  endtask

  task automatic test_chain();
    press(4'd11);
`ifdef CALC_CHAIN_EN
    total++;
    if ({state_dbg, alu_a, alu_op, disp_value} !== {3'd1, 8'd46, 2'd1, 8'd0}) begin
      bad++; $display("FAIL chain_op: st=%0d a=%0d op=%0d disp=%0d want 1/46/1/0",
                      state_dbg, alu_a, alu_op, disp_value);
    end
    press(4'd6); press(4'd14);
    total++;
    if ({alu_req, alu_a, alu_b, alu_op} !== {1'b1, 8'd46, 8'd6, 2'd1}) begin
      bad++; $display("FAIL chain_exec: req=%b a=%0d b=%0d op=%0d want 1/46/6/1",
                      alu_req, alu_a, alu_b, alu_op);
    end
    drive_cycle(1'b0, 4'd0, 1'b1, 1'b0, 8'd40, 1'b0);
    total++;
    if ({state_dbg, disp_value, alu_req} !== {3'd3, 8'd40, 1'b0}) begin
      bad++; $display("FAIL chain_show: st=%0d disp=%0d req=%b want 3/40/0", state_dbg, disp_value, alu_req);
    end
`else
    total++;
    if ({state_dbg, disp_value} !== {3'd3, 8'd46}) begin
      bad++; $display("FAIL show_op_ignored: st=%0d disp=%0d want 3/46", state_dbg, disp_value);
    end
    press(4'd6);
    total++;
    if ({state_dbg, disp_value, alu_a} !== {3'd0, 8'd6, 8'd6}) begin
      bad++; $display("FAIL show_digit: st=%0d disp=%0d a=%0d want 0/6/6", state_dbg, disp_value, alu_a);
    end
    press(4'd14);
    total++;
    if ({state_dbg, alu_req} !== {3'd0, 1'b0}) begin
      bad++; $display("FAIL eq_in_ent_a: st=%0d req=%b want 0/0", state_dbg, alu_req);
    end
`endif
  endtask

  task automatic test_digit_limits();
    press(4'd15); press(4'd2); press(4'd5); press(4'd6);
    total++;
    if (disp_value !== 8'd25) begin
      bad++; $display("FAIL overflow_reject: disp=%0d want 25", disp_value);
    end
    press(4'd15); press(4'd1); press(4'd0); press(4'd0); press(4'd7);
    total++;
    if (disp_value !== 8'd100) begin
      bad++; $display("FAIL digit_count: disp=%0d want 100", disp_value);
    end
    press(4'd15); press(4'd2); press(4'd5); press(4'd5);
    total++;
    if (disp_value !== 8'd255) begin
      bad++; $display("FAIL max_operand: disp=%0d want 255", disp_value);
    end
  endtask

  task automatic test_timeout();
    int n;
    n = 0;
    press(4'd15); press(4'd9); press(4'd13); press(4'd1); press(4'd14);
    while (alu_req && n < 40) begin
      n++;
      idle();
    end
    total++;
    if (n !== 15) begin
      bad++; $display("FAIL timeout_len: exec cycles=%0d want 15", n);
    end
    total++;
    if ({state_dbg, disp_err, alu_req, busy, disp_value} !== {3'd4, 1'b1, 1'b0, 1'b0, 8'd0}) begin
      bad++; $display("FAIL timeout_err: st=%0d err=%b req=%b busy=%b disp=%0d want 4/1/0/0/0",
                      state_dbg, disp_err, alu_req, busy, disp_value);
    end
    press(4'd15);
    total++;
    if ({state_dbg, disp_err, disp_value} !== {3'd0, 1'b0, 8'd0}) begin
      bad++; $display("FAIL err_clear: st=%0d err=%b disp=%0d want 0/0/0", state_dbg, disp_err, disp_value);
    end
  endtask

  task automatic test_alu_error();
    press(4'd15); press(4'd7); press(4'd13); press(4'd0); press(4'd14);
    total++;
    if ({state_dbg, alu_b, alu_op} !== {3'd2, 8'd0, 2'd3}) begin
      bad++; $display("FAIL div0_issue: st=%0d b=%0d op=%0d want 2/0/3", state_dbg, alu_b, alu_op);
    end
    drive_cycle(1'b0, 4'd0, 1'b1, 1'b1, 8'd0, 1'b0);
    total++;
    if ({state_dbg, disp_err, alu_req} !== {3'd4, 1'b1, 1'b0}) begin
      bad++; $display("FAIL alu_err: st=%0d err=%b req=%b want 4/1/0", state_dbg, disp_err, alu_req);
    end
    drive_cycle(1'b0, 4'd0, 1'b1, 1'b0, 8'd77, 1'b0);
    drive_cycle(1'b1, 4'd3, 1'b1, 1'b0, 8'd78, 1'b0);
    press(4'd14);
    total++;
    if ({state_dbg, disp_err, disp_value} !== {3'd4, 1'b1, 8'd0}) begin
      bad++; $display("FAIL err_sticky: st=%0d err=%b disp=%0d want 4/1/0", state_dbg, disp_err, disp_value);
    end
  endtask

  task automatic test_abort();
    press(4'd15); press(4'd1); press(4'd10); press(4'd2); press(4'd14);
    drive_cycle(1'b1, 4'd3, 1'b0, 1'b0, '0, 1'b1);
    total++;
    if ({alu_req, busy, disp_err, state_dbg, disp_value, alu_a, alu_b, alu_op} !== 32'd0) begin
      bad++; $display("FAIL reset_in_exec: req=%b st=%0d disp=%0d a=%0d b=%0d want all 0",
                      alu_req, state_dbg, disp_value, alu_a, alu_b);
    end
    press(4'd5); press(4'd10); press(4'd5); press(4'd14);
    drive_cycle(1'b1, 4'd15, 1'b1, 1'b0, 8'd99, 1'b0);
    idle();
    total++;
    if ({alu_req, state_dbg, disp_value, alu_a} !== {1'b0, 3'd0, 8'd0, 8'd0}) begin
      bad++; $display("FAIL clear_vs_ack: req=%b st=%0d disp=%0d a=%0d want 0/0/0/0",
                      alu_req, state_dbg, disp_value, alu_a);
    end
  endtask

  task automatic test_random();
    int ack_pct, r;
    logic kv, rst, ack;
    logic [3:0] kc;
    logic [31:0] exp, got;
    exp_q.delete();
    ack_pct = 20;
    for (int i = 0; i < 3000; i++) begin
      if (i % 64 == 0) begin
        r = $urandom_range(0, 2);
        ack_pct = (r == 0) ? 0 : ((r == 1) ? 15 : 60);
      end
      rst = ($urandom_range(0, 199) == 0);
      kv  = ($urandom_range(0, 2) == 0);
      r   = $urandom_range(0, 99);
      if (r < 55)      kc = 4'($urandom_range(0, 9));
      else if (r < 80) kc = 4'($urandom_range(10, 13));
      else if (r < 93) kc = 4'd14;
      else             kc = 4'd15;
      ack = ($urandom_range(0, 99) < ack_pct);
      drive_cycle(kv, kc, ack, ($urandom_range(0, 3) == 0), 8'($urandom_range(0, 255)), rst);
      exp = exp_q.pop_front();
      got = {alu_req, busy, disp_err, state_dbg, disp_value, alu_a, alu_b, alu_op};
      total++;
      if (got !== exp) begin
        bad++;
        $display("FAIL random cycle %0d: got req/busy/err=%b%b%b st=%0d disp=%0d a=%0d b=%0d op=%0d, want %b%b%b st=%0d disp=%0d a=%0d b=%0d op=%0d",
                 i, got[31], got[30], got[29], got[28:26], got[25:18], got[17:10], got[9:2], got[1:0],
                 exp[31], exp[30], exp[29], exp[28:26], exp[25:18], exp[17:10], exp[9:2], exp[1:0]);
      end
    end
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    test_reset();
    test_basic();
    test_chain();
    test_digit_limits();
    test_timeout();
    test_alu_error();
    test_abort();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
